// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes and the
// port-select used by the grant mux.
package dmem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        PORT_NONE,
        PORT_CORE,
        PORT_AUX
    } port_sel_e;

endpackage

// File: rtl/dmem_arb_starve.sv
// Counts consecutive cycles the aux port is denied; raises forced once the
// count reaches STARVE_LIMIT so aux can pre-empt the core for one cycle.
module dmem_arb_starve
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_b,
    input  logic a_req,
    input  logic a_gnt,
    output logic forced
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            starve_cnt <= '0;
        end else if (!a_req || a_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign forced = (starve_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / aux) arbiter in front of a single-port dmem: combinational
// grant and request mux, one-cycle registered read response per port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       c_req,
    input  logic                       c_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] c_addr,
    input  logic [31:0]                c_wdata,
    input  logic [1:0]                 c_size,
    input  logic                       c_notsigned,
    output logic                       c_gnt,
    output logic                       c_stall,
    output logic                       c_rvalid,
    output logic [31:0]                c_rdata,
    input  logic                       a_req,
    input  logic                       a_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] a_addr,
    input  logic [31:0]                a_wdata,
    input  logic [1:0]                 a_size,
    input  logic                       a_notsigned,
    output logic                       a_gnt,
    output logic                       a_rvalid,
    output logic [31:0]                a_rdata,
    output logic [DMEM_ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]                m_din,
    output logic                       m_read,
    output logic                       m_write,
    output logic [1:0]                 m_size,
    output logic                       m_notsigned,
    input  logic [31:0]                m_dout
);

    port_sel_e   sel;
    logic        forced;
    logic        c_vld_p1;
    logic        a_vld_p1;
    logic [31:0] c_rdata_p1;
    logic [31:0] a_rdata_p1;

    dmem_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .reset_b (reset_b),
        .a_req   (a_req),
        .a_gnt   (a_gnt),
        .forced  (forced)
    );

    // Stage p0: grant and dmem request mux. Reset gates every grant so no
    // write can reach dmem while reset_b is low.
    always_comb begin
        sel = PORT_NONE;
        if (reset_b) begin
            if (a_req && (!c_req || forced)) begin
                sel = PORT_AUX;
            end else if (c_req) begin
                sel = PORT_CORE;
            end
        end
    end

    assign c_gnt   = (sel == PORT_CORE);
    assign a_gnt   = (sel == PORT_AUX);
    assign c_stall = c_req && !c_gnt;

    always_comb begin
        m_addr      = '0;
        m_din       = '0;
        m_size      = '0;
        m_notsigned = 1'b0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        case (sel)
            PORT_CORE: begin
                m_addr      = c_addr;
                m_din       = c_wdata;
                m_size      = c_size;
                m_notsigned = c_notsigned;
                m_read      = !c_we;
                m_write     = c_we;
            end
            PORT_AUX: begin
                m_addr      = a_addr;
                m_din       = a_wdata;
                m_size      = a_size;
                m_notsigned = a_notsigned;
                m_read      = !a_we;
                m_write     = a_we;
            end
            default: ;
        endcase
    end

    // Stage p1: read response; rdata holds until that port's next read.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            c_vld_p1   <= 1'b0;
            a_vld_p1   <= 1'b0;
            c_rdata_p1 <= '0;
            a_rdata_p1 <= '0;
        end else begin
            c_vld_p1 <= c_gnt && !c_we;
            a_vld_p1 <= a_gnt && !a_we;
            if (c_gnt && !c_we) begin
                c_rdata_p1 <= m_dout;
            end
            if (a_gnt && !a_we) begin
                a_rdata_p1 <= m_dout;
            end
        end
    end

    assign c_rvalid = c_vld_p1;
    assign a_rvalid = a_vld_p1;
    assign c_rdata  = c_rdata_p1;
    assign a_rdata  = a_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: grant/mux model per cycle plus a
// read-response scoreboard per port.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW  = 10;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          c_req, c_we, c_notsigned;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata;
    logic [1:0]    c_size;
    logic          c_gnt, c_stall, c_rvalid;
    logic [31:0]   c_rdata;
    logic          a_req, a_we, a_notsigned;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata;
    logic [1:0]    a_size;
    logic          a_gnt, a_rvalid;
    logic [31:0]   a_rdata;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_din;
    logic          m_read, m_write, m_notsigned;
    logic [1:0]    m_size;
    logic [31:0]   m_dout;

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH(AW),
        .STARVE_LIMIT   (LIM)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .c_req       (c_req),
        .c_we        (c_we),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata),
        .c_size      (c_size),
        .c_notsigned (c_notsigned),
        .c_gnt       (c_gnt),
        .c_stall     (c_stall),
        .c_rvalid    (c_rvalid),
        .c_rdata     (c_rdata),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_size      (a_size),
        .a_notsigned (a_notsigned),
        .a_gnt       (a_gnt),
        .a_rvalid    (a_rvalid),
        .a_rdata     (a_rdata),
        .m_addr      (m_addr),
        .m_din       (m_din),
        .m_read      (m_read),
        .m_write     (m_write),
        .m_size      (m_size),
        .m_notsigned (m_notsigned),
        .m_dout      (m_dout)
    );

    always #5 clk = ~clk;

    // Read-only dmem stand-in: content is a fixed function of the address.
    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        if (a == 10'h010) return 32'hDEADBEEF;
        return 32'h5A00_0000 | (32'(a) * 32'h0001_0101);
    endfunction

    assign m_dout = init_word(m_addr);

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] c_q[$];
    logic [31:0] a_q[$];
    logic [31:0] c_last = '0;
    logic [31:0] a_last = '0;
    int          exp_cnt = 0;
    int          a_gnt_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_resp();
        logic [31:0] e;
        if (c_q.size() > 0) begin
            e = c_q.pop_front();
            check_eq("c_rvalid", c_rvalid, 1);
            check_eq("c_rdata", c_rdata, e);
            c_last = e;
        end else begin
            check_eq("c_rvalid_idle", c_rvalid, 0);
            check_eq("c_rdata_hold", c_rdata, c_last);
        end
        if (a_q.size() > 0) begin
            e = a_q.pop_front();
            check_eq("a_rvalid", a_rvalid, 1);
            check_eq("a_rdata", a_rdata, e);
            a_last = e;
        end else begin
            check_eq("a_rvalid_idle", a_rvalid, 0);
            check_eq("a_rdata_hold", a_rdata, a_last);
        end
    endtask

    task automatic cyc(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [31:0] cd, input logic [1:0] cs, input logic cn,
                       input logic ar, input logic aw, input logic [AW-1:0] aa,
                       input logic [31:0] ad, input logic [1:0] asz, input logic an);
        logic          eg_a, eg_c, e_rd, e_wr, e_ns;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_din;
        logic [1:0]    e_sz;
        @(negedge clk);
        check_resp();
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_size = cs; c_notsigned = cn;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad; a_size = asz; a_notsigned = an;
        #1;
        eg_a = reset_b && ar && (!cr || exp_cnt == LIM);
        eg_c = reset_b && cr && !eg_a;
        e_addr = '0; e_din = '0; e_sz = '0; e_ns = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        if (eg_a) begin
            e_addr = aa; e_din = ad; e_sz = asz; e_ns = an; e_rd = !aw; e_wr = aw;
        end else if (eg_c) begin
            e_addr = ca; e_din = cd; e_sz = cs; e_ns = cn; e_rd = !cw; e_wr = cw;
        end
        check_eq("c_gnt", c_gnt, eg_c);
        check_eq("a_gnt", a_gnt, eg_a);
        check_eq("c_stall", c_stall, cr && !eg_c);
        check_eq("m_read", m_read, e_rd);
        check_eq("m_write", m_write, e_wr);
        check_eq("m_addr", m_addr, e_addr);
        check_eq("m_din", m_din, e_din);
        check_eq("m_size", m_size, e_sz);
        check_eq("m_notsigned", m_notsigned, e_ns);
        if (eg_c && !cw) c_q.push_back(init_word(ca));
        if (eg_a && !aw) a_q.push_back(init_word(aa));
        if (eg_a) a_gnt_cnt++;
        if (!reset_b || !ar || eg_a) exp_cnt = 0;
        else if (exp_cnt < LIM) exp_cnt++;
    endtask

    task automatic idle();
        cyc(0, 0, '0, '0, SZ_WORD, 0, 0, 0, '0, '0, SZ_WORD, 0);
    endtask

    task automatic core_rd(input logic [AW-1:0] a);
        cyc(1, 0, a, '0, SZ_WORD, 0, 0, 0, '0, '0, SZ_WORD, 0);
    endtask

    task automatic both_rd(input logic [AW-1:0] ca, input logic [AW-1:0] aa);
        cyc(1, 0, ca, '0, SZ_WORD, 0, 1, 0, aa, '0, SZ_HALF, 1);
    endtask

    initial begin
        reset_b = 1'b0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_size = '0; c_notsigned = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_size = '0; a_notsigned = 0;

        // Requests during reset: nothing granted, core shows stall.
        both_rd(10'h005, 10'h006);
        cyc(1, 1, 10'h007, 32'h1111_2222, SZ_WORD, 0, 1, 1, 10'h008, 32'h3, SZ_BYTE, 0);
        @(posedge clk); #1 reset_b = 1'b1;

        // Single core read, then consecutive reads 1..3.
        core_rd(10'h010);
        idle();
        core_rd(10'h001);
        core_rd(10'h002);
        core_rd(10'h003);
        idle();
        idle();

        // Aux byte write while core idle; core half read with zero-extend.
        cyc(0, 0, '0, '0, SZ_WORD, 0, 1, 1, 10'h3FF, 32'h0000_00A5, SZ_BYTE, 0);
        idle();
        cyc(1, 0, 10'h044, '0, SZ_HALF, 1, 0, 0, '0, '0, SZ_WORD, 0);
        idle();

        // Continuous contention: forced aux grant every 5th cycle.
        a_gnt_cnt = 0;
        for (int i = 0; i < 15; i++) both_rd(AW'(10'h100 + i), AW'(10'h200 + i));
        check_eq("aux_forced_count", a_gnt_cnt, 3);
        idle();

        // Aux denied 3 cycles, withdraws, then needs 4 fresh denials.
        a_gnt_cnt = 0;
        for (int i = 0; i < 3; i++) both_rd(AW'(10'h120 + i), 10'h2A0);
        core_rd(10'h123);
        for (int i = 0; i < 4; i++) both_rd(AW'(10'h130 + i), 10'h2A1);
        check_eq("aux_no_early_grant", a_gnt_cnt, 0);
        both_rd(10'h134, 10'h2A1);
        check_eq("aux_grant_after_4", a_gnt_cnt, 1);
        idle();

        // Reset right after a core read grant cancels the response.
        core_rd(10'h020);
        @(posedge clk); #1 reset_b = 1'b0;
        c_q.delete(); a_q.delete(); c_last = '0; a_last = '0; exp_cnt = 0;
        cyc(1, 1, 10'h021, 32'hCAFE_F00D, SZ_WORD, 0, 1, 1, 10'h022, 32'h77, SZ_BYTE, 0);
        @(posedge clk); #1 reset_b = 1'b1;

        // Arbitration resumes with a fresh starvation count.
        a_gnt_cnt = 0;
        for (int i = 0; i < 5; i++) both_rd(AW'(10'h030 + i), 10'h2B0);
        check_eq("resume_forced", a_gnt_cnt, 1);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
